// File: rtl/prbs_checker_if.sv
// Stream bus between a PRBS word source and the prbs_checker.
// The data path carries a valid-only stream. A word transfers on every rising
// clock edge where valid_i is 1. There is no ready, because the checker accepts
// a word on every cycle. Counter clear, the status outputs and the FSM debug
// state also travel on this bus.
interface prbs_checker_if #(
    parameter int WIDTH     = 10,
    parameter int CNT_WIDTH = 16
);
    logic                 valid_i;
    logic [WIDTH-1:0]     data_i;
    logic                 clear_i;
    logic                 locked_o;
    logic                 err_o;
    logic [CNT_WIDTH-1:0] err_word_cnt_o;
    logic [CNT_WIDTH-1:0] err_bit_cnt_o;
    logic                 dbg_state_o;

    // Source side: drives words and clear, observes status
    modport master (
        output valid_i,
        output data_i,
        output clear_i,
        input  locked_o,
        input  err_o,
        input  err_word_cnt_o,
        input  err_bit_cnt_o,
        input  dbg_state_o
    );

    // Checker side
    modport slave (
        input  valid_i,
        input  data_i,
        input  clear_i,
        output locked_o,
        output err_o,
        output err_word_cnt_o,
        output err_bit_cnt_o,
        output dbg_state_o
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS word checker.
// In SEARCH the checker predicts each word from the previous received word. It
// declares lock after LOCK_COUNT consecutive correct predictions. In LOCKED it
// predicts from its own free-running copy of the LFSR, so one corrupted word
// costs exactly one word error. UNLOCK_COUNT consecutive misses drop it back to
// SEARCH. Both error counters saturate at all-ones.
module prbs_checker #(
    parameter int               WIDTH        = 10,
    parameter logic [WIDTH-1:0] TAPS         = 10'h2C2,
    parameter int               LOCK_COUNT   = 8,
    parameter int               UNLOCK_COUNT = 4,
    parameter int               CNT_WIDTH    = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    prbs_checker_if.slave if_bus
);

    // Counter widths: each counter must be able to hold its terminal value
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);
    localparam int PW = $clog2(WIDTH + 1);
    // The bit-count sum is one bit wider than its widest operand, so the
    // saturation test sees the carry out
    localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
    localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Next word of the LFSR: shift left and insert the masked parity
    function automatic logic [WIDTH-1:0] f_nxt(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], ^(w & TAPS)};
    endfunction

    // Number of set bits in a word
    function automatic logic [PW-1:0] f_popcount(input logic [WIDTH-1:0] w);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PW'(w[i]);
        end
        return n;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MW-1:0]        r_match_cnt;
    logic [UW-1:0]        r_miss_cnt;
    logic                 r_have_prev;
    logic [WIDTH-1:0]     r_prev;
    logic [WIDTH-1:0]     r_exp;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic [CNT_WIDTH-1:0] r_bit_cnt;

    logic                 w_valid;
    logic                 w_clear;
    logic [WIDTH-1:0]     w_data;
    logic                 w_hit;
    logic [MW-1:0]        w_match_inc;
    logic                 w_lock_reach;
    logic                 w_mismatch;
    logic [UW-1:0]        w_miss_inc;
    logic                 w_unlock_reach;
    logic [PW-1:0]        w_pop;
    logic [SW-1:0]        w_bit_sum;
    logic [CNT_WIDTH-1:0] w_word_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_bit_cnt_nxt;

    assign w_valid = if_bus.valid_i;
    assign w_clear = if_bus.clear_i;
    assign w_data  = if_bus.data_i;

    // SEARCH prediction: an all-zero word never counts as a hit, because the
    // LFSR lock-up state would otherwise "lock" on a dead link
    assign w_hit        = r_have_prev && (w_data == f_nxt(r_prev)) && (w_data != '0);
    assign w_match_inc  = r_match_cnt + MW'(1);
    assign w_lock_reach = w_hit && (w_match_inc == MW'(LOCK_COUNT));

    // LOCKED prediction comes only from the free-running expectation register
    assign w_mismatch     = (w_data != r_exp);
    assign w_miss_inc     = r_miss_cnt + UW'(1);
    assign w_unlock_reach = w_mismatch && (w_miss_inc == UW'(UNLOCK_COUNT));

    // Saturating error accumulation; the bit add is clamped, never wrapped
    assign w_pop          = f_popcount(w_data ^ r_exp);
    assign w_bit_sum      = SW'(r_bit_cnt) + SW'(w_pop);
    assign w_bit_cnt_nxt  = (w_bit_sum > SW'(C_MAX)) ? C_MAX : w_bit_sum[CNT_WIDTH-1:0];
    assign w_word_cnt_nxt = (r_word_cnt == C_MAX) ? C_MAX : (r_word_cnt + CNT_WIDTH'(1));

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: moves only on valid words
    always_comb begin
        w_state_nxt = r_state;
        if (w_valid) begin
            case (r_state)
                ST_SEARCH: if (w_lock_reach)   w_state_nxt = ST_LOCKED;
                ST_LOCKED: if (w_unlock_reach) w_state_nxt = ST_SEARCH;
                default:                       w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    // FSM outputs: lock status and debug state decode straight from the state flop
    always_comb begin
        if_bus.locked_o       = (r_state == ST_LOCKED);
        if_bus.dbg_state_o    = r_state;
        if_bus.err_o          = r_err;
        if_bus.err_word_cnt_o = r_word_cnt;
        if_bus.err_bit_cnt_o  = r_bit_cnt;
    end

    // Datapath: prediction registers, match/miss runs, error pulse and counters
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_have_prev <= 1'b0;
            r_prev      <= '0;
            r_exp       <= '0;
            r_err       <= 1'b0;
            r_word_cnt  <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_valid) begin
                if (r_state == ST_SEARCH) begin
                    r_prev      <= w_data;
                    r_have_prev <= 1'b1;
                    r_match_cnt <= w_hit ? w_match_inc : '0;
                    if (w_lock_reach) begin
                        r_exp      <= f_nxt(w_data);
                        r_miss_cnt <= '0;
                    end
                end else begin
                    // The expectation keeps running whether or not the word matched
                    r_exp <= f_nxt(r_exp);
                    if (!w_mismatch) begin
                        r_miss_cnt <= '0;
                    end else begin
                        r_err      <= 1'b1;
                        r_miss_cnt <= w_miss_inc;
                        r_word_cnt <= w_word_cnt_nxt;
                        r_bit_cnt  <= w_bit_cnt_nxt;
                        if (w_unlock_reach) begin
                            r_match_cnt <= '0;
                            r_have_prev <= 1'b0;
                        end
                    end
                end
            end
            // Clear wins over a same-cycle increment; the err pulse is kept
            if (w_clear) begin
                r_word_cnt <= '0;
                r_bit_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed PRBS streams with hand-computed checkpoints,
// plus a cycle-by-cycle scoreboard fed from a reference model of the checker.
// The counters are built narrow here (4 bits), so saturation is reachable quickly.
module tb_prbs_checker;

    localparam int               WIDTH   = 10;
    localparam int               CW      = 4;
    localparam int               LOCK_N  = 8;
    localparam int               UNLOCK_N = 4;
    localparam logic [WIDTH-1:0] TB_TAPS = 10'h2C2;
    localparam logic [WIDTH-1:0] SEED    = 10'h2AA;
    localparam int               CMAX    = (1 << CW) - 1;
    localparam int               EW      = 2 + 2 * CW;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    prbs_checker_if #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) bus ();

    prbs_checker #(
        .WIDTH       (WIDTH),
        .TAPS        (TB_TAPS),
        .LOCK_COUNT  (LOCK_N),
        .UNLOCK_COUNT(UNLOCK_N),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .if_bus(bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the checker
    logic             m_locked;
    logic             m_err;
    logic             m_have;
    logic [WIDTH-1:0] m_prev;
    logic [WIDTH-1:0] m_exp;
    int               m_match;
    int               m_miss;
    int               m_wc;
    int               m_bc;

    // Transmitter-side LFSR used to build the stimulus
    logic [WIDTH-1:0] seq;

    function automatic logic [WIDTH-1:0] tb_nxt(input logic [WIDTH-1:0] w);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (TB_TAPS[i]) fb = fb ^ w[i];
        end
        return {w[WIDTH-2:0], fb};
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Advance the model by one clock edge with the given inputs
    task automatic model_step(input logic rn, input logic v, input logic [WIDTH-1:0] d,
                              input logic c);
        logic hit;
        if (!rn) begin
            m_locked = 1'b0; m_err = 1'b0; m_have = 1'b0;
            m_prev = '0; m_exp = '0;
            m_match = 0; m_miss = 0; m_wc = 0; m_bc = 0;
        end else begin
            m_err = 1'b0;
            if (v) begin
                if (!m_locked) begin
                    hit = m_have && (d == tb_nxt(m_prev)) && (d != '0);
                    m_match = hit ? m_match + 1 : 0;
                    m_prev = d;
                    m_have = 1'b1;
                    if (m_match == LOCK_N) begin
                        m_locked = 1'b1;
                        m_exp = tb_nxt(d);
                        m_miss = 0;
                    end
                end else begin
                    if (d == m_exp) begin
                        m_miss = 0;
                    end else begin
                        m_err = 1'b1;
                        m_wc = sat_add(m_wc, 1);
                        m_bc = sat_add(m_bc, $countones(d ^ m_exp));
                        m_miss++;
                        if (m_miss == UNLOCK_N) begin
                            m_locked = 1'b0;
                            m_match = 0;
                            m_have = 1'b0;
                        end
                    end
                    m_exp = tb_nxt(m_exp);
                end
            end
            if (c) begin
                m_wc = 0;
                m_bc = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle of stimulus; the expected post-edge outputs go on the queue
    task automatic drive(input logic rn, input logic v, input logic [WIDTH-1:0] d,
                         input logic c);
        @(negedge clk_i);
        rst_ni      = rn;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.clear_i = c;
        model_step(rn, v, d, c);
        exp_q.push_back({m_locked, m_err, CW'(m_wc), CW'(m_bc)});
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Send n consecutive sequence words; optional random idle cycles before each
    task automatic send_seq(input int n, input bit gapped);
        for (int k = 0; k < n; k++) begin
            if (gapped) begin
                while ($urandom_range(0, 1) == 1) begin
                    drive(1'b1, 1'b0, WIDTH'($urandom_range(0, 1023)), 1'b0);
                end
            end
            drive(1'b1, 1'b1, seq, 1'b0);
            seq = tb_nxt(seq);
        end
    endtask

    // Send one sequence word corrupted by mask (the sequence still advances)
    task automatic send_err(input logic [WIDTH-1:0] mask, input logic c);
        drive(1'b1, 1'b1, seq ^ mask, c);
        seq = tb_nxt(seq);
    endtask

    // Wait until just after the edge that consumes the last driven cycle
    task automatic settle();
        @(posedge clk_i);
        #2;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_locked",   32'(bus.locked_o),       32'(e[EW-1]));
                check("sb_err",      32'(bus.err_o),          32'(e[EW-2]));
                check("sb_word_cnt", 32'(bus.err_word_cnt_o), 32'(e[2*CW-1:CW]));
                check("sb_bit_cnt",  32'(bus.err_bit_cnt_o),  32'(e[CW-1:0]));
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int drain;
        rst_ni      = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.clear_i = 1'b0;

        // 1: reset state, then lock on the sequence from 0x2AA
        do_reset();
        settle();
        check("rst_locked", 32'(bus.locked_o), 32'd0);
        check("rst_word",   32'(bus.err_word_cnt_o), 32'd0);
        seq = SEED;
        send_seq(1, 1'b0);
        check("seed_word", 32'(bus.data_i), 32'h2AA);
        send_seq(1, 1'b0);
        check("second_word", 32'(bus.data_i), 32'h155);
        send_seq(6, 1'b0);
        settle();
        check("t1_no_lock_w8", 32'(bus.locked_o), 32'd0);
        send_seq(1, 1'b0);
        settle();
        check("t1_lock_w9", 32'(bus.locked_o), 32'd1);
        check("t1_word",    32'(bus.err_word_cnt_o), 32'd0);
        check("t1_bit",     32'(bus.err_bit_cnt_o), 32'd0);

        // 2: flip bits 0 and 3 of one word while locked
        send_err(10'h009, 1'b0);
        settle();
        check("t2_err",  32'(bus.err_o), 32'd1);
        check("t2_word", 32'(bus.err_word_cnt_o), 32'd1);
        check("t2_bit",  32'(bus.err_bit_cnt_o), 32'd2);
        send_seq(1, 1'b0);
        settle();
        check("t2_err_clear", 32'(bus.err_o), 32'd0);
        check("t2_word_hold", 32'(bus.err_word_cnt_o), 32'd1);
        check("t2_locked",    32'(bus.locked_o), 32'd1);

        // 3: four garbage words drop lock, then relock after 8 hits
        send_err(10'h001, 1'b0);
        send_err(10'h001, 1'b0);
        send_err(10'h001, 1'b0);
        settle();
        check("t3_still_locked", 32'(bus.locked_o), 32'd1);
        send_err(10'h001, 1'b0);
        settle();
        check("t3_unlocked", 32'(bus.locked_o), 32'd0);
        check("t3_word",     32'(bus.err_word_cnt_o), 32'd5);
        check("t3_bit",      32'(bus.err_bit_cnt_o), 32'd6);
        send_seq(8, 1'b0);
        settle();
        check("t3_no_relock_w8", 32'(bus.locked_o), 32'd0);
        send_seq(1, 1'b0);
        settle();
        check("t3_relock", 32'(bus.locked_o), 32'd1);

        // 4: constant zero never locks
        do_reset();
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, '0, 1'b0);
        settle();
        check("t4_locked", 32'(bus.locked_o), 32'd0);
        check("t4_word",   32'(bus.err_word_cnt_o), 32'd0);

        // 5: saturation of both counters, then clear racing an error
        do_reset();
        seq = SEED;
        send_seq(9, 1'b0);
        for (int k = 0; k < 14; k++) begin
            send_err(10'h040, 1'b0);
            send_seq(1, 1'b0);
        end
        settle();
        check("t5_word_e", 32'(bus.err_word_cnt_o), 32'd14);
        check("t5_bit_e",  32'(bus.err_bit_cnt_o), 32'd14);
        send_err(10'h007, 1'b0);
        settle();
        check("t5_word_f", 32'(bus.err_word_cnt_o), 32'd15);
        check("t5_bit_clamp", 32'(bus.err_bit_cnt_o), 32'd15);
        send_seq(1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            send_err(10'h100, 1'b0);
            send_seq(1, 1'b0);
        end
        settle();
        check("t5_word_sat", 32'(bus.err_word_cnt_o), 32'd15);
        check("t5_bit_sat",  32'(bus.err_bit_cnt_o), 32'd15);
        send_err(10'h001, 1'b1);
        settle();
        check("t5_clr_err",    32'(bus.err_o), 32'd1);
        check("t5_clr_word",   32'(bus.err_word_cnt_o), 32'd0);
        check("t5_clr_bit",    32'(bus.err_bit_cnt_o), 32'd0);
        check("t5_clr_locked", 32'(bus.locked_o), 32'd1);

        // 6: gapped valid keeps lock timing in valid words; reset mid-lock
        do_reset();
        seq = 10'h3C1;
        send_seq(8, 1'b1);
        settle();
        check("t6_no_lock_w8", 32'(bus.locked_o), 32'd0);
        send_seq(1, 1'b1);
        settle();
        check("t6_lock_w9", 32'(bus.locked_o), 32'd1);
        drive(1'b1, 1'b0, '0, 1'b0);
        settle();
        check("t6_idle_locked", 32'(bus.locked_o), 32'd1);
        send_err(10'h030, 1'b0);
        send_seq(3, 1'b1);
        drive(1'b0, 1'b1, seq, 1'b0);
        settle();
        check("t6_rst_locked", 32'(bus.locked_o), 32'd0);
        check("t6_rst_err",    32'(bus.err_o), 32'd0);
        check("t6_rst_word",   32'(bus.err_word_cnt_o), 32'd0);
        check("t6_rst_bit",    32'(bus.err_bit_cnt_o), 32'd0);
        send_seq(12, 1'b1);

        // Drain the scoreboard with a bounded wait
        drive(1'b1, 1'b0, '0, 1'b0);
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk_i);
            drain++;
        end
        #3;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
